// File: rtl/multi_channel_timer_core.sv
// multi_channel_timer_core
//
// A bank of CHANNELS independent BCD time counters. Each counter is either an
// up-counting stopwatch or a down-counting timer. All counters advance on one
// shared centisecond prescaler tick. Digits are packed MSB nibble first:
// {decahr, hr, decamin, min, decasec, sec, decisec, centisec}.
//
// Ports
//   clk_i          system clock (only clock)
//   reset_i        synchronous active-high reset
//   sel_i          channel addressed by commands and by the display
//   start_i        pulse: run the selected channel
//   pause_i        pulse: pause the selected channel
//   clear_i        pulse: zero the selected channel and make it idle
//   load_i         pulse: load load_value_i / dir_i into the selected channel
//   dir_i          0 = count up (stopwatch), 1 = count down (timer)
//   load_value_i   BCD value to load
//   disp_bcd_o     registered value of channel sel_i (0 if sel_i is out of range)
//   running_o      per-channel RUN state
//   expired_o      per-channel DONE state (sticky until clear/load)
//   alarm_o        one-cycle pulse when any channel enters DONE
//   load_err_o     one-cycle pulse when a load is rejected
//   tick_o         prescaler tick, one cycle wide
module multi_channel_timer_core #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 500000,
  parameter int SELW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [SELW-1:0]     sel_i,
  input  logic                start_i,
  input  logic                pause_i,
  input  logic                clear_i,
  input  logic                load_i,
  input  logic                dir_i,
  input  logic [31:0]         load_value_i,
  output logic [31:0]         disp_bcd_o,
  output logic [CHANNELS-1:0] running_o,
  output logic [CHANNELS-1:0] expired_o,
  output logic                alarm_o,
  output logic                load_err_o,
  output logic                tick_o
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [31:0]     VALUE_MAX = 32'h9959_5999;
  localparam logic [SELW:0]   SEL_LIMIT = (SELW + 1)'(CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSED,
    ST_DONE
  } chan_state_t;

  chan_state_t         state_q [CHANNELS];
  chan_state_t         state_d [CHANNELS];
  logic [31:0]         value_q [CHANNELS];
  logic [31:0]         value_d [CHANNELS];
  logic [CHANNELS-1:0] dir_q;
  logic [CHANNELS-1:0] dir_d;
  logic [CHANNELS-1:0] done_entry;
  logic [PW-1:0]       presc_q;
  logic                tick;
  logic                sel_valid;
  logic                load_ok;
  logic                load_err_d;
  logic                alarm_d;
  logic [31:0]         disp_d;

  // Largest legal value of digit i (0 = centisec). Tens-of-seconds and
  // tens-of-minutes stop at 5, every other digit at 9.
  function automatic logic [3:0] digit_max(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic bcd_valid(input logic [31:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (v[i*4 +: 4] > digit_max(i)) ok = 1'b0;
    end
    return ok;
  endfunction

  // Ripple a +1 up the digit chain; a digit at its maximum wraps to 0 and
  // carries. Never called on VALUE_MAX, which saturates instead.
  function automatic logic [31:0] bcd_inc(input logic [31:0] v);
    logic [31:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (carry) begin
        if (v[i*4 +: 4] >= digit_max(i)) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Mirror of bcd_inc: a zero digit reloads its maximum and borrows.
  function automatic logic [31:0] bcd_dec(input logic [31:0] v);
    logic [31:0] r;
    logic        borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (borrow) begin
        if (v[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = digit_max(i);
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Free-running prescaler; commands never touch it.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      presc_q <= '0;
    end else if (presc_q == TICK_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign tick      = (presc_q == TICK_LAST);
  assign tick_o    = tick;
  assign sel_valid = ({1'b0, sel_i} < SEL_LIMIT);
  assign load_ok   = bcd_valid(load_value_i);

  // Channel next-state logic. The if/else chain encodes command precedence
  // (clear > load > pause > start) and makes any command on the selected
  // channel suppress that channel's advance on a coincident tick. A start on
  // a channel already in RUN is a no-op and does not block its advance.
  always_comb begin
    logic hit;
    hit        = 1'b0;
    disp_d     = 32'd0;
    done_entry = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      state_d[k] = state_q[k];
      value_d[k] = value_q[k];
      dir_d[k]   = dir_q[k];
      hit        = sel_valid && (sel_i == SELW'(k));

      if (hit) disp_d = value_q[k];

      if (hit && clear_i) begin
        state_d[k] = ST_IDLE;
        value_d[k] = 32'd0;
      end else if (hit && load_i) begin
        // A rejected load still consumes the cycle: channel left untouched.
        if (load_ok) begin
          state_d[k] = ST_IDLE;
          value_d[k] = load_value_i;
          dir_d[k]   = dir_i;
        end
      end else if (hit && pause_i) begin
        if (state_q[k] == ST_RUN) state_d[k] = ST_PAUSED;
      end else if (hit && start_i && state_q[k] != ST_RUN) begin
        // A down-counter sitting at zero has nothing to count; stay idle.
        if (state_q[k] == ST_PAUSED ||
            (state_q[k] == ST_IDLE && !(dir_q[k] && value_q[k] == 32'd0))) begin
          state_d[k] = ST_RUN;
        end
      end else if (state_q[k] == ST_RUN && tick) begin
        if (!dir_q[k]) begin
          if (value_q[k] == VALUE_MAX) begin
            state_d[k]    = ST_DONE;
            done_entry[k] = 1'b1;
          end else begin
            value_d[k] = bcd_inc(value_q[k]);
          end
        end else begin
          if (value_q[k] <= 32'd1) begin
            value_d[k]    = 32'd0;
            state_d[k]    = ST_DONE;
            done_entry[k] = 1'b1;
          end else begin
            value_d[k] = bcd_dec(value_q[k]);
          end
        end
      end
    end
  end

  assign alarm_d    = |done_entry;
  assign load_err_d = sel_valid && load_i && !clear_i && !load_ok;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= ST_IDLE;
        value_q[k] <= 32'd0;
      end
      dir_q      <= '0;
      disp_bcd_o <= 32'd0;
      alarm_o    <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        state_q[k] <= state_d[k];
        value_q[k] <= value_d[k];
      end
      dir_q      <= dir_d;
      disp_bcd_o <= disp_d;
      alarm_o    <= alarm_d;
      load_err_o <= load_err_d;
    end
  end

  always_comb begin
    running_o = '0;
    expired_o = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      running_o[k] = (state_q[k] == ST_RUN);
      expired_o[k] = (state_q[k] == ST_DONE);
    end
  end

endmodule

// File: tb/tb_multi_channel_timer_core.sv
// Directed bench for multi_channel_timer_core with CHANNELS=4, TICK_DIV=4.
// Inputs change and outputs are sampled on the falling edge, so every command
// applied by apply_stimulus lands on the following rising edge.
module tb_multi_channel_timer_core;

  localparam int CHANNELS = 4;
  localparam int TICK_DIV = 4;
  localparam int SELW     = 2;

  logic                clk;
  logic                reset_i;
  logic [SELW-1:0]     sel_i;
  logic                start_i;
  logic                pause_i;
  logic                clear_i;
  logic                load_i;
  logic                dir_i;
  logic [31:0]         load_value_i;
  logic [31:0]         disp_bcd_o;
  logic [CHANNELS-1:0] running_o;
  logic [CHANNELS-1:0] expired_o;
  logic                alarm_o;
  logic                load_err_o;
  logic                tick_o;

  int n_compared   = 0;
  int n_mismatched = 0;

  multi_channel_timer_core #(
    .CHANNELS (CHANNELS),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .sel_i        (sel_i),
    .start_i      (start_i),
    .pause_i      (pause_i),
    .clear_i      (clear_i),
    .load_i       (load_i),
    .dir_i        (dir_i),
    .load_value_i (load_value_i),
    .disp_bcd_o   (disp_bcd_o),
    .running_o    (running_o),
    .expired_o    (expired_o),
    .alarm_o      (alarm_o),
    .load_err_o   (load_err_o),
    .tick_o       (tick_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    assert (observed === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle command pulse on channel ch; returns on the next falling edge.
  task automatic apply_stimulus(input logic [SELW-1:0] ch, input logic c_clear,
                                input logic c_load, input logic c_pause,
                                input logic c_start, input logic d,
                                input logic [31:0] v);
    sel_i        = ch;
    clear_i      = c_clear;
    load_i       = c_load;
    pause_i      = c_pause;
    start_i      = c_start;
    dir_i        = d;
    load_value_i = v;
    @(negedge clk);
    clear_i = 1'b0;
    load_i  = 1'b0;
    pause_i = 1'b0;
    start_i = 1'b0;
  endtask

  // Advance to a falling edge where tick_o is high (next rising edge ticks).
  task automatic sync_tick();
    int n;
    n = 0;
    while (tick_o !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_output("tick_sync", {31'b0, tick_o}, 32'h1);
  endtask

  // Start a loaded channel off-tick, let exactly one tick pass, pause it,
  // then wait one cycle so disp_bcd_o shows the result.
  task automatic run_one_tick(input logic [SELW-1:0] ch);
    sync_tick();
    step(1);
    apply_stimulus(ch, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    sync_tick();
    step(1);
    apply_stimulus(ch, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1);
  endtask

  initial begin
    int          alarm_seen;
    logic [31:0] exp_val;

    reset_i      = 1'b1;
    sel_i        = '0;
    start_i      = 1'b0;
    pause_i      = 1'b0;
    clear_i      = 1'b0;
    load_i       = 1'b0;
    dir_i        = 1'b0;
    load_value_i = 32'd0;
    step(2);

    // Reset state
    check_output("rst_disp",     disp_bcd_o,           32'h0);
    check_output("rst_running",  {28'b0, running_o},   32'h0);
    check_output("rst_expired",  {28'b0, expired_o},   32'h0);
    check_output("rst_alarm",    {31'b0, alarm_o},     32'h0);
    check_output("rst_load_err", {31'b0, load_err_o},  32'h0);
    check_output("rst_tick",     {31'b0, tick_o},      32'h0);
    reset_i = 1'b0;

    // Prescaler: tick_o high only when the count reaches 3
    step(1); check_output("presc_c1", {31'b0, tick_o}, 32'h0);
    step(1); check_output("presc_c2", {31'b0, tick_o}, 32'h0);
    step(1); check_output("presc_c3", {31'b0, tick_o}, 32'h1);
    step(1); check_output("presc_c0", {31'b0, tick_o}, 32'h0);

    // Stopwatch on ch0: one increment per tick, 10 ticks -> 0x10
    apply_stimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    apply_stimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("sw_running", {28'b0, running_o}, 32'h1);
    for (int i = 1; i <= 10; i++) begin
      sync_tick();
      step(2);
      exp_val = (i == 10) ? 32'h0000_0010 : 32'(i);
      check_output("sw_count", disp_bcd_o, exp_val);
    end
    check_output("sw_expired", {28'b0, expired_o}, 32'h0);

    // Pause on a tick cycle: value must not advance
    sync_tick();
    apply_stimulus(2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    step(1);
    check_output("pause_tick_val", disp_bcd_o,         32'h0000_0010);
    check_output("pause_running",  {28'b0, running_o}, 32'h0);
    sync_tick();
    step(2);
    check_output("pause_hold_val", disp_bcd_o, 32'h0000_0010);

    // Timer expiry on ch2 from 0x02
    sync_tick();
    step(1);
    apply_stimulus(2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0002);
    apply_stimulus(2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("tmr_running", {28'b0, running_o}, 32'h4);
    alarm_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (alarm_o === 1'b1) alarm_seen++;
    end
    check_output("tmr_alarm_count", 32'(alarm_seen),      32'd1);
    check_output("tmr_expired",     {28'b0, expired_o},   32'h4);
    check_output("tmr_running_end", {28'b0, running_o},   32'h0);
    check_output("tmr_value",       disp_bcd_o,           32'h0);

    // Carry and borrow on ch1
    apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0059_5999);
    run_one_tick(2'd1);
    check_output("carry", disp_bcd_o, 32'h0100_0000);
    apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0100_0000);
    run_one_tick(2'd1);
    check_output("borrow", disp_bcd_o, 32'h0059_5999);

    // Overflow saturation on ch1
    apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h9959_5999);
    sync_tick();
    step(1);
    apply_stimulus(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    sync_tick();
    step(1);
    check_output("ovf_alarm",   {31'b0, alarm_o},   32'h1);
    check_output("ovf_expired", {28'b0, expired_o}, 32'h6);
    check_output("ovf_running", {28'b0, running_o}, 32'h0);
    step(1);
    check_output("ovf_alarm_off", {31'b0, alarm_o}, 32'h0);
    check_output("ovf_value",     disp_bcd_o,       32'h9959_5999);
    apply_stimulus(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("done_start_ign", {28'b0, expired_o}, 32'h6);

    // Independence: start ch1 while ch3 runs
    apply_stimulus(2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    step(1);
    apply_stimulus(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0500);
    apply_stimulus(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    sync_tick();
    step(1);
    apply_stimulus(2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("indep_running", {28'b0, running_o}, 32'ha);
    sel_i = 2'd3;
    step(1);
    check_output("indep_ch3_val", disp_bcd_o, 32'h0000_0501);

    // Clear and start together on running ch3, on a tick cycle
    step(1);
    apply_stimulus(2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("clr_running", {28'b0, running_o}, 32'h2);
    check_output("clr_expired", {28'b0, expired_o}, 32'h4);
    step(1);
    check_output("clr_value", disp_bcd_o, 32'h0);

    // Down-counter at zero refuses to start
    apply_stimulus(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    apply_stimulus(2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("zero_timer_idle", {28'b0, running_o}, 32'h2);

    // Rejected loads on paused ch0 (value 0x10, up)
    apply_stimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0060_0000);
    check_output("bad_decamin_err", {31'b0, load_err_o}, 32'h1);
    step(1);
    check_output("bad_decamin_err_off", {31'b0, load_err_o}, 32'h0);
    check_output("bad_decamin_val",     disp_bcd_o,          32'h0000_0010);
    apply_stimulus(2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_000A);
    check_output("bad_digit_err", {31'b0, load_err_o}, 32'h1);
    step(1);
    check_output("bad_digit_err_off", {31'b0, load_err_o}, 32'h0);
    check_output("bad_digit_val",     disp_bcd_o,          32'h0000_0010);

    // Resume ch0: still counts up, so direction was not replaced
    apply_stimulus(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    check_output("resume_running", {28'b0, running_o}, 32'h3);
    sync_tick();
    step(2);
    check_output("resume_up", disp_bcd_o, 32'h0000_0011);

    // Reset while channels run
    reset_i = 1'b1;
    step(1);
    check_output("mid_rst_disp",     disp_bcd_o,          32'h0);
    check_output("mid_rst_running",  {28'b0, running_o},  32'h0);
    check_output("mid_rst_expired",  {28'b0, expired_o},  32'h0);
    check_output("mid_rst_alarm",    {31'b0, alarm_o},    32'h0);
    check_output("mid_rst_load_err", {31'b0, load_err_o}, 32'h0);
    check_output("mid_rst_tick",     {31'b0, tick_o},     32'h0);
    reset_i = 1'b0;
    step(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/multi_channel_timer_core.md
# multi_channel_timer_core

Bank of CHANNELS independent BCD time counters, each configurable as an up-counting stopwatch or a down-counting timer, driven by one shared centisecond prescaler. It is the parametrised successor to the single clock/stopwatch/timer trio. Per-channel command pulses come from the existing button interpreters. The selected channel's eight BCD digits feed the 7-segment output manager. Expiry flags drive the blink/alarm logic.

## Interface
- CHANNELS, 4: number of counter channels, 1..16.
- TICK_DIV, 500000: clk_i cycles per centisecond tick, ≥2.
- SELW, $clog2(CHANNELS) (min 1): width of sel_i.

- clk_i  in  1  system clock; the only clock.
- reset_i  in  1  synchronous, active-high reset.
- sel_i  in  SELW  channel addressed by commands and by the display.
- start_i  in  1  single-cycle pulse: run the selected channel.
- pause_i  in  1  single-cycle pulse: pause the selected channel.
- clear_i  in  1  single-cycle pulse: zero the selected channel and make it idle.
- load_i  in  1  single-cycle pulse: load load_value_i and dir_i into the selected channel.
- dir_i  in  1  direction sampled on load: 0 = count up (stopwatch), 1 = count down (timer).
- load_value_i  in  32  BCD digits {decahr, hr, decamin, min, decasec, sec, decisec, centisec}, MSB nibble first.
- disp_bcd_o  out  32  registered value of channel sel_i, same nibble order.
- running_o  out  CHANNELS  per-channel RUN state.
- expired_o  out  CHANNELS  per-channel DONE state (sticky).
- alarm_o  out  1  one-cycle pulse when any channel enters DONE.
- load_err_o  out  1  one-cycle pulse when a load is rejected.
- tick_o  out  1  prescaler tick, one cycle wide.

## Operation
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick_o = 1 in the cycle the count equals TICK_DIV-1. It free-runs from reset and is not affected by any command.
- Per-channel state machine: IDLE, RUN, PAUSED, DONE.
  - IDLE: start → RUN, except dir=1 with value 0, which stays IDLE.
  - RUN: pause → PAUSED.
  - RUN, dir=0, tick at 99:59:59.99: value holds at max; → DONE.
  - RUN, dir=1, tick at 00:00:00.01: value becomes 0; → DONE.
  - PAUSED: start → RUN.
  - DONE: start and pause are ignored.
  - Any state: clear → IDLE, value 0, dir kept.
  - Any state: valid load → IDLE, value and dir replaced.
- Command precedence, applied to channel sel_i only: clear > load > pause > start. Exactly one command takes effect per cycle.
- If sel_i ≥ CHANNELS, all commands are ignored and disp_bcd_o shows 0.
- Load validation:
  - Every digit must be ≤9, and decasec and decamin must be ≤5.
  - If validation fails, the channel is unchanged and load_err_o pulses.
- BCD arithmetic on each tick while in RUN:
  - Up: centisec wraps 9→0 and carries into decisec, and so on up the chain. sec wraps at 9, decasec at 5, min at 9, decamin at 5, hr at 9, decahr at 9.
  - Down: borrows mirror the up chain. Digits below zero reload 9 (or 5 for the tens-of-sec and tens-of-min digits).
  - All channels in RUN advance on the same tick.
- expired_o[k] = 1 exactly while channel k is in DONE.
- alarm_o is the OR over channels of the DONE-entry events.

## Timing
- Reset values: all channel values 0, dir 0, all channels IDLE, prescaler 0. All outputs (disp_bcd_o, running_o, expired_o, alarm_o, load_err_o, tick_o) are 0.
- Commands sampled at edge n update state and value at edge n (visible from cycle n+1). running_o and expired_o are registered state, so they are visible from cycle n+1.
- disp_bcd_o is registered from channel sel_i's current value, so it lags the value register by one cycle. A change of sel_i is reflected one cycle later.
- Tick in the same cycle as start on an IDLE or PAUSED channel: no advance. The first advance occurs on the next tick.
- Tick in the same cycle as pause, clear or load: the command wins and there is no advance.
- alarm_o and the DONE transition are asserted in the cycle after the terminal tick edge. load_err_o is asserted in the cycle after the rejected load.
- reset_i asserted mid-count returns everything to reset values at the next edge, with no alarm pulse.

## Test plan
- Prescaler and stopwatch:
  - Stimulus: TICK_DIV=4, CHANNELS=4. Load ch0 with dir=0, value 0, then start.
  - Required: ch0 increments once every 4 cycles. After 10 ticks disp_bcd_o = 0x00000010.
- Timer expiry:
  - Stimulus: ch2 loaded with 0x00000002, dir=1, then started.
  - Required: after 2 ticks the value is 0, expired_o = 4'b0100, alarm_o pulses exactly once, running_o[2] = 0.
- Carry and borrow:
  - Stimulus: up-count from 0x00595999, one tick.
  - Required: 0x01000000. Down-count from 0x01000000, one tick → 0x00595999.
- Overflow saturation:
  - Stimulus: up-count from 0x99595999, one tick.
  - Required: the value stays 0x99595999, the channel enters DONE, alarm_o pulses.
- Precedence and simultaneity:
  - Stimulus: clear and start in the same cycle on a running channel. Required: IDLE, value 0.
  - Stimulus: pause on a tick cycle. Required: the value is unchanged.
  - Stimulus: start on ch1 while ch3 is running. Required: ch3 is unaffected.
- Invalid input and reset:
  - Stimulus: load 0x00600000. Required: the load is rejected, load_err_o pulses, the value is unchanged.
  - Stimulus: load 0x0000000A. Required: the same rejection behaviour.
  - Stimulus: reset_i asserted during RUN. Required: all outputs 0 on the next cycle.
